// File: rtl/regfile_mp_scoreboard.sv
// Multi-port register bank for the pipelined ARM core: 3 combinational reads, 2 synchronous writes,
// per-register pending bits for multi-cycle units, optional same-cycle write forwarding, PC aliased to R15.
module regfile_mp_scoreboard #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned PC_IDX = 15,
  parameter int unsigned BYPASS = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [DATA_W-1:0] RD3,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] WA3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              WE4,
  input  logic [ADDR_W-1:0] WA4,
  input  logic [DATA_W-1:0] WD4,
  input  logic [DATA_W-1:0] R15,
  input  logic              RSV_EN,
  input  logic [ADDR_W-1:0] RSV_A,
  output logic              BUSY1,
  output logic              BUSY2,
  output logic              BUSY3,
  output logic              ANY_PEND
);

  localparam int unsigned       DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_A  = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;

  logic [ADDR_W-1:0] ra   [3];
  logic [DATA_W-1:0] rd   [3];
  logic [2:0]        busy;

  // Port 3 is applied after port 4 so it wins an address conflict;
  // the reservation is applied last so it wins over a clearing write.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ADDR_W'(i) != PC_A) begin
        if (WE4 && (WA4 == ADDR_W'(i))) regs_d[i] = WD4;
        if (WE3 && (WA3 == ADDR_W'(i))) regs_d[i] = WD3;
        if ((WE3 && (WA3 == ADDR_W'(i))) || (WE4 && (WA4 == ADDR_W'(i)))) pend_d[i] = 1'b0;
        if (RSV_EN && (RSV_A == ADDR_W'(i))) pend_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  assign ra[0] = A1;
  assign ra[1] = A2;
  assign ra[2] = A3;

  // Forwarding is suppressed during reset so reads show the stored value, not data about to be dropped.
  always_comb begin
    for (int unsigned k = 0; k < 3; k++) begin
      rd[k]   = regs_q[ra[k]];
      busy[k] = 1'b0;
      if (ra[k] == PC_A) begin
        rd[k] = R15;
      end else begin
        busy[k] = pend_q[ra[k]];
        if ((BYPASS != 0) && !RESET) begin
          if (WE3 && (WA3 == ra[k]))      rd[k] = WD3;
          else if (WE4 && (WA4 == ra[k])) rd[k] = WD4;
        end
      end
    end
  end

  assign RD1      = rd[0];
  assign RD2      = rd[1];
  assign RD3      = rd[2];
  assign BUSY1    = busy[0];
  assign BUSY2    = busy[1];
  assign BUSY3    = busy[2];
  assign ANY_PEND = |pend_q;

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed bench for regfile_mp_scoreboard (BYPASS=1): reset, writes, conflicts, PC alias, scoreboard.
module tb_regfile_mp_scoreboard;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  A1, A2, A3, WA3, WA4, RSV_A;
  logic [31:0] RD1, RD2, RD3, WD3, WD4, R15;
  logic        WE3, WE4, RSV_EN;
  logic        BUSY1, BUSY2, BUSY3, ANY_PEND;

  int errors = 0;
  int checks = 0;

  regfile_mp_scoreboard #(.DATA_W(32), .ADDR_W(4), .PC_IDX(15), .BYPASS(1)) dut (
    .CLK(CLK), .RESET(RESET),
    .A1(A1), .A2(A2), .A3(A3),
    .RD1(RD1), .RD2(RD2), .RD3(RD3),
    .WE3(WE3), .WA3(WA3), .WD3(WD3),
    .WE4(WE4), .WA4(WA4), .WD4(WD4),
    .R15(R15), .RSV_EN(RSV_EN), .RSV_A(RSV_A),
    .BUSY1(BUSY1), .BUSY2(BUSY2), .BUSY3(BUSY3), .ANY_PEND(ANY_PEND)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    WE3 = 0; WE4 = 0; RSV_EN = 0; RESET = 0;
  endtask

  task automatic test_reset();
    WE3 = 1; WA3 = 3; WD3 = 32'hDEADBEEF;
    tick(); idle();
    A1 = 3; #1;
    checks++; if (RD1 !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_prewrite: got %h expected %h", RD1, 32'hDEADBEEF); end
    RESET = 1; WE3 = 1; WA3 = 3; WD3 = 32'h11111111; RSV_EN = 1; RSV_A = 4; #1;
    checks++; if (RD1 !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_no_bypass: got %h expected %h", RD1, 32'hDEADBEEF); end
    tick(); idle(); #1;
    checks++; if (RD1 !== 32'h0) begin errors++; $display("FAIL rst_rd1: got %h expected %h", RD1, 32'h0); end
    checks++; if (ANY_PEND !== 1'b0) begin errors++; $display("FAIL rst_anypend: got %b expected 0", ANY_PEND); end
    A2 = 4; #1;
    checks++; if ({BUSY1, BUSY2} !== 2'b00) begin errors++; $display("FAIL rst_busy: got %b expected 00", {BUSY1, BUSY2}); end
  endtask

  task automatic test_write_read();
    A2 = 5; A3 = 6;
    WE3 = 1; WA3 = 5; WD3 = 32'h12345678;
    WE4 = 1; WA4 = 6; WD4 = 32'hCAFEF00D; #1;
    checks++; if (RD2 !== 32'h12345678) begin errors++; $display("FAIL wr_bypass3: got %h expected %h", RD2, 32'h12345678); end
    checks++; if (RD3 !== 32'hCAFEF00D) begin errors++; $display("FAIL wr_bypass4: got %h expected %h", RD3, 32'hCAFEF00D); end
    tick(); idle(); #1;
    checks++; if (RD2 !== 32'h12345678) begin errors++; $display("FAIL wr_stored3: got %h expected %h", RD2, 32'h12345678); end
    checks++; if (RD3 !== 32'hCAFEF00D) begin errors++; $display("FAIL wr_stored4: got %h expected %h", RD3, 32'hCAFEF00D); end
  endtask

  task automatic test_conflict();
    A1 = 7;
    WE3 = 1; WA3 = 7; WD3 = 32'h1;
    WE4 = 1; WA4 = 7; WD4 = 32'h2; #1;
    checks++; if (RD1 !== 32'h1) begin errors++; $display("FAIL conf_bypass: got %h expected %h", RD1, 32'h1); end
    tick(); idle(); #1;
    checks++; if (RD1 !== 32'h1) begin errors++; $display("FAIL conf_stored: got %h expected %h", RD1, 32'h1); end
  endtask

  task automatic test_pc_alias();
    R15 = 32'h108; A1 = 15; A2 = 15; A3 = 15;
    WE3 = 1; WA3 = 15; WD3 = 32'hFF; RSV_EN = 1; RSV_A = 15; #1;
    checks++; if ({RD1, RD2, RD3} !== {3{32'h108}}) begin errors++; $display("FAIL pc_same_cycle: got %h %h %h expected 108", RD1, RD2, RD3); end
    tick(); idle(); #1;
    checks++; if ({RD1, RD2, RD3} !== {3{32'h108}}) begin errors++; $display("FAIL pc_next: got %h %h %h expected 108", RD1, RD2, RD3); end
    checks++; if ({BUSY1, BUSY2, BUSY3, ANY_PEND} !== 4'b0000) begin errors++; $display("FAIL pc_busy: got %b expected 0000", {BUSY1, BUSY2, BUSY3, ANY_PEND}); end
    R15 = 32'h200; #1;
    checks++; if (RD1 !== 32'h200) begin errors++; $display("FAIL pc_follow: got %h expected %h", RD1, 32'h200); end
  endtask

  task automatic test_scoreboard();
    A1 = 9; A2 = 8; A3 = 9;
    RSV_EN = 1; RSV_A = 9; #1;
    checks++; if (BUSY1 !== 1'b0) begin errors++; $display("FAIL sb_not_yet: got %b expected 0", BUSY1); end
    tick(); idle(); #1;
    checks++; if ({BUSY1, BUSY2, BUSY3, ANY_PEND} !== 4'b1011) begin errors++; $display("FAIL sb_set: got %b expected 1011", {BUSY1, BUSY2, BUSY3, ANY_PEND}); end
    WE4 = 1; WA4 = 9; WD4 = 32'h99; #1;
    checks++; if (BUSY1 !== 1'b1) begin errors++; $display("FAIL sb_hold: got %b expected 1", BUSY1); end
    tick(); idle(); #1;
    checks++; if ({BUSY1, ANY_PEND} !== 2'b00) begin errors++; $display("FAIL sb_clear: got %b expected 00", {BUSY1, ANY_PEND}); end
    checks++; if (RD1 !== 32'h99) begin errors++; $display("FAIL sb_data: got %h expected %h", RD1, 32'h99); end
  endtask

  task automatic test_simultaneous();
    A2 = 2;
    RSV_EN = 1; RSV_A = 2; WE3 = 1; WA3 = 2; WD3 = 32'hA5;
    tick(); idle(); #1;
    checks++; if (RD2 !== 32'hA5) begin errors++; $display("FAIL sim_data: got %h expected %h", RD2, 32'hA5); end
    checks++; if (BUSY2 !== 1'b1) begin errors++; $display("FAIL sim_busy: got %b expected 1", BUSY2); end
    RSV_EN = 1; RSV_A = 2;
    tick(); RSV_A = 11;
    tick(); idle(); A3 = 11; #1;
    checks++; if ({BUSY2, BUSY3, ANY_PEND} !== 3'b111) begin errors++; $display("FAIL sim_rereserve: got %b expected 111", {BUSY2, BUSY3, ANY_PEND}); end
    RESET = 1;
    tick(); idle(); #1;
    checks++; if ({BUSY2, BUSY3, ANY_PEND} !== 3'b000) begin errors++; $display("FAIL sim_reset: got %b expected 000", {BUSY2, BUSY3, ANY_PEND}); end
    checks++; if (RD2 !== 32'h0) begin errors++; $display("FAIL sim_reset_data: got %h expected %h", RD2, 32'h0); end
  endtask

  task automatic test_back_to_back();
    WE3 = 1; WA3 = 1; WD3 = 32'h11; WE4 = 1; WA4 = 8; WD4 = 32'h88;
    tick();
    WE4 = 0; WD3 = 32'h22;
    tick(); idle();
    A1 = 1; A2 = 8; A3 = 0; #1;
    checks++; if ({RD1, RD2, RD3} !== {32'h22, 32'h88, 32'h0}) begin errors++; $display("FAIL b2b: got %h %h %h expected 22 88 0", RD1, RD2, RD3); end
  endtask

  initial begin
    RESET = 1; A1 = 0; A2 = 0; A3 = 0;
    WE3 = 0; WA3 = 0; WD3 = 0; WE4 = 0; WA4 = 0; WD4 = 0;
    R15 = 32'h8; RSV_EN = 0; RSV_A = 0;
    tick(); idle(); #1;
    checks++; if ({RD1, ANY_PEND, BUSY1} !== {32'h0, 2'b00}) begin errors++; $display("FAIL init: got %h %b%b expected 0 00", RD1, ANY_PEND, BUSY1); end
    test_reset();
    test_write_read();
    test_conflict();
    test_pc_alias();
    test_scoreboard();
    test_simultaneous();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
